stdmacro_pipe_skid: RTL and testbench



---
 rtl/stdmacro_pipe_skid_pkg.sv | 19 +
 rtl/stdmacro_dff.sv | 33 +++
 rtl/stdmacro_pipe_skid.sv | 178 +++++++++++++++++
 tb/tb_stdmacro_pipe_skid.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/stdmacro_pipe_skid_pkg.sv
// -----------------------------------------------------------------------------
// stdmacro_pipe_skid_pkg
//   Shared constants for the skid-buffered pipeline stage: width and
//   encodings of the 2-bit occupancy state.
//     EMPTY : no beat held
//     BUSY  : one beat held in the output register
//     FULL  : output register and skid register both hold a beat
//   The fourth code is unused and recovers to EMPTY.
// -----------------------------------------------------------------------------
package stdmacro_pipe_skid_pkg;

    localparam int          STDMACRO_SKID_STATE_W = 2;

    localparam logic [1:0]  STDMACRO_SKID_EMPTY   = 2'b00;
    localparam logic [1:0]  STDMACRO_SKID_BUSY    = 2'b01;
    localparam logic [1:0]  STDMACRO_SKID_FULL    = 2'b10;
    localparam logic [1:0]  STDMACRO_SKID_ILLEGAL = 2'b11;

endpackage : stdmacro_pipe_skid_pkg

// File: rtl/stdmacro_dff.sv
// -----------------------------------------------------------------------------
// stdmacro_dff
//   Generic enabled D flip-flop bank with synchronous, active-high reset
//   that clears the bank to zero. Reset takes priority over the enable.
//   Non-zero reset values are produced by the instantiating module by muxing
//   its reset value into d and forcing en while its own reset is high.
//
// Ports:
//   clk   - clock, state updates on rising edge
//   reset - synchronous active-high clear to zero
//   en    - load enable
//   d     - next value
//   q     - registered value
// -----------------------------------------------------------------------------
module stdmacro_dff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule : stdmacro_dff

// File: rtl/stdmacro_pipe_skid.sv
// -----------------------------------------------------------------------------
// stdmacro_pipe_skid
//   Single-stage valid/ready pipeline register with a one-entry skid buffer.
//   m_valid, s_ready and m_data are all register outputs, so there is no
//   combinational path from m_ready to s_ready or from s_valid/s_data to
//   m_valid/m_data.
//
// Handshake: a beat moves across an interface on a rising edge where both
//   valid and ready are high. Once m_valid rises it stays high, with m_data
//   held stable, until the downstream transfer. s_data is don't-care when no
//   upstream transfer happens. Beats are never dropped, duplicated or
//   reordered except by reset, which discards everything held.
//
// Ports:
//   clk     - core clock
//   reset   - synchronous active-high reset, overrides any handshake
//   s_valid - upstream payload valid
//   s_ready - block can accept a beat this cycle
//   s_data  - upstream payload
//   m_valid - downstream payload valid
//   m_ready - downstream accepts this cycle
//   m_data  - downstream payload
//   state   - occupancy state, debug visibility only
// -----------------------------------------------------------------------------
module stdmacro_pipe_skid
    import stdmacro_pipe_skid_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_DATA = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [1:0]            state
);

    logic [STDMACRO_SKID_STATE_W-1:0] state_q;
    logic [STDMACRO_SKID_STATE_W-1:0] state_d;

    logic                  out_load;
    logic [DATA_WIDTH-1:0] out_next;
    logic                  skid_load;

    logic                  out_reg_en;
    logic [DATA_WIDTH-1:0] out_reg_d;
    logic [DATA_WIDTH-1:0] out_q;
    logic                  skid_reg_en;
    logic [DATA_WIDTH-1:0] skid_reg_d;
    logic [DATA_WIDTH-1:0] skid_q;

    // ---------------------------------------------------------------------
    // State register (EMPTY encodes as zero, so the plain clear suffices)
    // ---------------------------------------------------------------------
    stdmacro_dff #(
        .WIDTH (STDMACRO_SKID_STATE_W)
    ) u_state_reg (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .d     (state_d),
        .q     (state_q)
    );

    // ---------------------------------------------------------------------
    // Next-state and data-enable logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        out_load  = 1'b0;
        out_next  = s_data;
        skid_load = 1'b0;

        case (state_q)
            STDMACRO_SKID_EMPTY: begin
                if (s_valid) begin
                    out_load = 1'b1;
                    state_d  = STDMACRO_SKID_BUSY;
                end
            end

            STDMACRO_SKID_BUSY: begin
                if (s_valid && m_ready) begin
                    out_load = 1'b1;
                end else if (s_valid) begin
                    // Downstream stalled: park the new beat, keep out_reg.
                    skid_load = 1'b1;
                    state_d   = STDMACRO_SKID_FULL;
                end else if (m_ready) begin
                    // out_reg keeps its stale value; m_valid masks it.
                    state_d = STDMACRO_SKID_EMPTY;
                end
            end

            STDMACRO_SKID_FULL: begin
                // s_ready is low here, so s_valid cannot be a transfer.
                if (m_ready) begin
                    out_load = 1'b1;
                    out_next = skid_q;
                    state_d  = STDMACRO_SKID_BUSY;
                end
            end

            default: begin
                state_d = STDMACRO_SKID_EMPTY;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Data registers. Their dff reset is tied off; reset instead forces a
    // load of RESET_DATA so any reset value, not only zero, is supported.
    // ---------------------------------------------------------------------
    assign out_reg_en  = reset | out_load;
    assign out_reg_d   = reset ? RESET_DATA : out_next;
    assign skid_reg_en = reset | skid_load;
    assign skid_reg_d  = reset ? RESET_DATA : s_data;

    stdmacro_dff #(
        .WIDTH (DATA_WIDTH)
    ) u_out_reg (
        .clk   (clk),
        .reset (1'b0),
        .en    (out_reg_en),
        .d     (out_reg_d),
        .q     (out_q)
    );

    stdmacro_dff #(
        .WIDTH (DATA_WIDTH)
    ) u_skid_reg (
        .clk   (clk),
        .reset (1'b0),
        .en    (skid_reg_en),
        .d     (skid_reg_d),
        .q     (skid_q)
    );

    // ---------------------------------------------------------------------
    // Outputs, decoded from the registered state only
    // ---------------------------------------------------------------------
    always_comb begin
        m_valid = 1'b0;
        s_ready = 1'b1;
        case (state_q)
            STDMACRO_SKID_EMPTY: begin
                m_valid = 1'b0;
                s_ready = 1'b1;
            end
            STDMACRO_SKID_BUSY: begin
                m_valid = 1'b1;
                s_ready = 1'b1;
            end
            STDMACRO_SKID_FULL: begin
                m_valid = 1'b1;
                s_ready = 1'b0;
            end
            default: begin
                m_valid = 1'b0;
                s_ready = 1'b0;
            end
        endcase
    end

    assign m_data = out_q;
    assign state  = state_q;

    // The unused fourth encoding must fall back to EMPTY on the next edge.
    illegal_state_recovers : assert property (
        @(posedge clk) disable iff (reset)
        (state_q == STDMACRO_SKID_ILLEGAL) |=> (state_q == STDMACRO_SKID_EMPTY)
    );

endmodule : stdmacro_pipe_skid

// File: tb/tb_stdmacro_pipe_skid.sv
module tb_stdmacro_pipe_skid;
    import stdmacro_pipe_skid_pkg::*;

    localparam int           W     = 32;
    localparam logic [W-1:0] RST_D = 32'hCAFE_F00D;

    logic         clk;
    logic         reset;
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_data;
    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] m_data;
    logic [1:0]   state;

    int checks   = 0;
    int failures = 0;

    // Reference model: the beats currently held, oldest first, plus the
    // value last presented on m_data (it is retained when the stage empties).
    logic [W-1:0] mq[$];
    logic [W-1:0] last_out = RST_D;
    // Scoreboard of beats observed entering, checked as they leave.
    logic [W-1:0] exp_q[$];

    stdmacro_pipe_skid #(
        .DATA_WIDTH (W),
        .RESET_DATA (RST_D)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .state   (state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    // ---------------- model helpers ----------------
    function automatic logic [1:0] exp_state();
        case (mq.size())
            0:       return STDMACRO_SKID_EMPTY;
            1:       return STDMACRO_SKID_BUSY;
            default: return STDMACRO_SKID_FULL;
        endcase
    endfunction

    // One clock: advance the model using the inputs present at the edge,
    // then settle 1 time unit past the edge for sampling.
    task automatic tick();
        bit up;
        bit dn;
        up = !reset && s_valid && (mq.size() < 2);
        dn = !reset && m_ready && (mq.size() > 0);
        @(posedge clk);
        if (reset) begin
            mq.delete();
            last_out = RST_D;
        end else begin
            if (dn) void'(mq.pop_front());
            if (up) mq.push_back(s_data);
            if (mq.size() > 0) last_out = mq[0];
        end
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; s_valid = 1'b1; s_data = 32'hDEAD; m_ready = 1'b0;
        tick(); tick();
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%0b want=0", m_valid); end
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_s_ready got=%0b want=1", s_ready); end
        checks++; if (m_data !== RST_D) begin failures++; $display("FAIL reset_m_data got=%h want=%h", m_data, RST_D); end
        checks++; if (state !== STDMACRO_SKID_EMPTY) begin failures++; $display("FAIL reset_state got=%0d want=%0d", state, STDMACRO_SKID_EMPTY); end
        reset = 1'b0; s_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_no_beat cyc=%0d got=%0b want=0", i, m_valid); end
        end
    endtask

    task automatic test_streaming();
        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            s_valid = 1'b1; s_data = W'(i);
            tick();
            checks++; if (m_valid !== 1'b1 || m_data !== W'(i)) begin failures++; $display("FAIL stream_beat i=%0d got=%0b/%h want=1/%h", i, m_valid, m_data, W'(i)); end
            checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL stream_s_ready i=%0d got=%0b want=1", i, s_ready); end
        end
        s_valid = 1'b0;
        tick();
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL stream_drain got=%0b want=0", m_valid); end
    endtask

    task automatic test_skid_fill();
        m_ready = 1'b0; s_valid = 1'b1; s_data = 32'hA;
        tick();
        checks++; if (state !== STDMACRO_SKID_BUSY || m_data !== 32'hA) begin failures++; $display("FAIL skid_busy got=%0d/%h want=%0d/a", state, m_data, STDMACRO_SKID_BUSY); end
        s_data = 32'hB;
        tick();
        checks++; if (state !== STDMACRO_SKID_FULL) begin failures++; $display("FAIL skid_full_state got=%0d want=%0d", state, STDMACRO_SKID_FULL); end
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL skid_full_s_ready got=%0b want=0", s_ready); end
        checks++; if (m_data !== 32'hA) begin failures++; $display("FAIL skid_full_m_data got=%h want=a", m_data); end
        s_valid = 1'b1; s_data = 32'hBAD;  // ignored: s_ready is low
        tick();
        checks++; if (m_data !== 32'hA || state !== STDMACRO_SKID_FULL) begin failures++; $display("FAIL skid_hold got=%h/%0d want=a/%0d", m_data, state, STDMACRO_SKID_FULL); end
        s_valid = 1'b0; m_ready = 1'b1;
        tick();
        checks++; if (m_data !== 32'hB || m_valid !== 1'b1) begin failures++; $display("FAIL skid_second got=%0b/%h want=1/b", m_valid, m_data); end
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL skid_s_ready_back got=%0b want=1", s_ready); end
        tick();
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL skid_drain got=%0b want=0", m_valid); end
    endtask

    task automatic test_reset_in_full();
        m_ready = 1'b0; s_valid = 1'b1; s_data = 32'h11;
        tick();
        s_data = 32'h22;
        tick();
        checks++; if (state !== STDMACRO_SKID_FULL) begin failures++; $display("FAIL rfull_setup got=%0d want=%0d", state, STDMACRO_SKID_FULL); end
        reset = 1'b1; s_valid = 1'b1; s_data = 32'h33; m_ready = 1'b1;
        tick();
        checks++; if (m_valid !== 1'b0 || s_ready !== 1'b1) begin failures++; $display("FAIL rfull_flags got=%0b/%0b want=0/1", m_valid, s_ready); end
        checks++; if (m_data !== RST_D) begin failures++; $display("FAIL rfull_m_data got=%h want=%h", m_data, RST_D); end
        reset = 1'b0; s_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (m_valid !== 1'b0 || m_data !== RST_D) begin failures++; $display("FAIL rfull_no_beat cyc=%0d got=%0b/%h want=0/%h", i, m_valid, m_data, RST_D); end
        end
    endtask

    task automatic test_simultaneous();
        m_ready = 1'b0; s_valid = 1'b1; s_data = 32'h4;
        tick();
        m_ready = 1'b1;
        for (int v = 5; v <= 7; v++) begin
            s_data = W'(v);
            tick();
            checks++; if (m_data !== W'(v) || state !== STDMACRO_SKID_BUSY) begin failures++; $display("FAIL simul v=%0d got=%h/%0d want=%h/%0d", v, m_data, state, W'(v), STDMACRO_SKID_BUSY); end
        end
        s_valid = 1'b0;
        tick();
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL simul_drain got=%0b want=0", m_valid); end
    endtask

    task automatic test_random_backpressure();
        bit           dn_obs;
        bit           stalled;
        logic [W-1:0] got;
        logic [W-1:0] want;
        reset = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
        tick();
        reset = 1'b0;
        exp_q.delete();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            s_valid = 1'($urandom_range(0, 1));
            s_data  = $urandom;
            m_ready = 1'($urandom_range(0, 1));
            if (s_valid && s_ready) exp_q.push_back(s_data);
            dn_obs  = m_valid && m_ready;
            stalled = m_valid && !m_ready;
            got     = m_data;
            tick();
            if (dn_obs) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL rand_extra_beat cyc=%0d got=%h want=none", cyc, got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin failures++; $display("FAIL rand_order cyc=%0d got=%h want=%h", cyc, got, want); end
                end
            end
            if (stalled) begin
                checks++; if (m_valid !== 1'b1 || m_data !== got) begin failures++; $display("FAIL rand_stall_stable cyc=%0d got=%0b/%h want=1/%h", cyc, m_valid, m_data, got); end
            end
            checks++; if (m_valid !== (mq.size() > 0)) begin failures++; $display("FAIL rand_m_valid cyc=%0d got=%0b want=%0b", cyc, m_valid, mq.size() > 0); end
            checks++; if (s_ready !== (mq.size() < 2)) begin failures++; $display("FAIL rand_s_ready cyc=%0d got=%0b want=%0b", cyc, s_ready, mq.size() < 2); end
            checks++; if (m_data !== last_out) begin failures++; $display("FAIL rand_m_data cyc=%0d got=%h want=%h", cyc, m_data, last_out); end
            checks++; if (state !== exp_state()) begin failures++; $display("FAIL rand_state cyc=%0d got=%0d want=%0d", cyc, state, exp_state()); end
            if (state == STDMACRO_SKID_FULL) begin
                checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL rand_ready_in_full cyc=%0d got=%0b want=0", cyc, s_ready); end
            end
        end
        checks++; if (exp_q.size() !== mq.size()) begin failures++; $display("FAIL rand_in_flight got=%0d want=%0d", exp_q.size(), mq.size()); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        reset = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        test_reset();
        test_streaming();
        test_skid_fill();
        test_reset_in_full();
        test_simultaneous();
        test_random_backpressure();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_stdmacro_pipe_skid
